// File: rtl/forest_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// forest_ctrl_pkg
// Shared types and helpers for the forest batch sequencer.
//   seq_state_t  : batch sequencer FSM states
//   res_width()  : width of a tree_summer_fixed result for a given forest shape
//   DEF_RES_W    : default result width (4 samples x depth-4 trees)
// -----------------------------------------------------------------------------
package forest_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_MEM = 3'd1,
        ST_LOAD     = 3'd2,
        ST_FEED     = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } seq_state_t;

    // Sum of samples*treeDepth leaf values plus 4 bits of leaf magnitude.
    function automatic int res_width(input int samples, input int tree_depth);
        return $clog2(samples * tree_depth) + 4;
    endfunction

    localparam int DEF_RES_W = res_width(4, 4);

endpackage

// File: rtl/forest_batch_sequencer_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Small synchronous FIFO holding per-sample sums until downstream pops them.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, din       write one entry (ignored when full without a pop)
//   pop             remove head entry (ignored when empty)
//   flush           discard all contents
//   valid, dout     FIFO not empty / head entry (0 when empty)
//   count           current fill level
// -----------------------------------------------------------------------------
module result_fifo #(
    parameter int RES_W     = 8,
    parameter int RES_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [RES_W-1:0]               din,
    input  logic                           pop,
    input  logic                           flush,
    output logic                           valid,
    output logic [RES_W-1:0]               dout,
    output logic [$clog2(RES_DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(RES_DEPTH);
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RES_DEPTH);

    logic [RES_W-1:0] mem_q [RES_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only safe when the head leaves in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FULL) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RES_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push && !flush) mem_q[wr_ptr_q] <= din;
        end
    end

    assign valid = (count_q != '0);
    assign dout  = valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/forest_batch_sequencer.sv
// -----------------------------------------------------------------------------
// forest_batch_sequencer
// Runs one classification batch through the forest datapath: waits for the
// threshold memory, pulls data blocks from upstream, enables the sample feeder
// only while result-FIFO credit remains, collects tree sums and signals done.
// A watchdog aborts the batch when nothing moves for TIMEOUT cycles.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start, numBlocks         batch request (sampled in IDLE) and block count
//   busy, done, error        status: not idle / completion pulse / fault pulse
//   memRdy                   threshold memory ready
//   blkValid, blkReady       upstream data-block handshake
//   feedLoad, feedEnable     sample_feeder load pulse and enable
//   sampValid, sampRec       feeder output valid / first pipeline node accepted
//   unitDone, sumIn          tree_summer_fixed result strobe and value
//   resValid, resReady       result FIFO handshake toward downstream
//   resData                  FIFO head
// -----------------------------------------------------------------------------
module forest_batch_sequencer
    import forest_ctrl_pkg::*;
#(
    parameter int SAMP_PER_BLK = 4,
    parameter int RES_W        = DEF_RES_W,
    parameter int RES_DEPTH    = 4,
    parameter int BLK_W        = 8,
    parameter int TIMEOUT      = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [BLK_W-1:0] numBlocks,
    output logic             busy,
    output logic             done,
    output logic             error,
    input  logic             memRdy,
    input  logic             blkValid,
    output logic             blkReady,
    output logic             feedLoad,
    output logic             feedEnable,
    input  logic             sampValid,
    input  logic             sampRec,
    input  logic             unitDone,
    input  logic [RES_W-1:0] sumIn,
    output logic             resValid,
    input  logic             resReady,
    output logic [RES_W-1:0] resData
);

    localparam int CNT_W  = $clog2(RES_DEPTH + 1);
    localparam int SAMP_W = $clog2(SAMP_PER_BLK + 1);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    seq_state_t       state_q, state_d;
    logic [BLK_W-1:0] blocks_left_q, blocks_left_d;
    logic [SAMP_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             feed_load_q, feed_load_d;
    logic             zero_done_q, zero_done_d;
    logic             error_q, error_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_sum;
    logic             credit_ok;
    logic             samp_acc;
    logic             blk_acc;
    logic             res_push;
    logic             res_pop;
    logic             spurious;
    logic             wd_active;
    logic             progress;
    logic             timeout;

    // One extra bit so outstanding + fifo + 1 cannot wrap.
    assign credit_sum = {1'b0, outstanding_q} + {1'b0, fifo_count} + (CNT_W+1)'(1);
    assign credit_ok  = (credit_sum <= (CNT_W+1)'(RES_DEPTH));

    assign feedEnable = (state_q == ST_FEED) && memRdy && credit_ok;
    assign blkReady   = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE) || zero_done_q;
    assign error      = error_q;
    assign feedLoad   = feed_load_q;

    // Accepts are only counted while enabled, so the credit check always holds.
    assign samp_acc = feedEnable && sampValid && sampRec;
    assign blk_acc  = (state_q == ST_LOAD) && blkValid;
    assign res_push = unitDone && (outstanding_q != '0);
    assign spurious = unitDone && (outstanding_q == '0);
    assign res_pop  = resValid && resReady;

    assign wd_active = (state_q == ST_WAIT_MEM) || (state_q == ST_LOAD) ||
                       (state_q == ST_FEED)     || (state_q == ST_DRAIN);
    assign progress  = samp_acc || unitDone || res_pop || blk_acc;
    assign timeout   = wd_active && !progress && (wd_cnt_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d       = state_q;
        blocks_left_d = blocks_left_q;
        samp_cnt_d    = samp_cnt_q;
        outstanding_d = outstanding_q;
        feed_load_d   = 1'b0;
        zero_done_d   = 1'b0;
        error_d       = spurious;

        // Simultaneous accept and result leave the count unchanged.
        if (samp_acc && !res_push)      outstanding_d = outstanding_q + CNT_W'(1);
        else if (!samp_acc && res_push) outstanding_d = outstanding_q - CNT_W'(1);

        if (!wd_active || progress) wd_cnt_d = '0;
        else                        wd_cnt_d = wd_cnt_q + WD_W'(1);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (numBlocks != '0) begin
                        blocks_left_d = numBlocks;
                        state_d       = ST_WAIT_MEM;
                    end else begin
                        zero_done_d = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (memRdy) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (blkValid) begin
                    feed_load_d = 1'b1;
                    samp_cnt_d  = '0;
                    state_d     = ST_FEED;
                end
            end
            ST_FEED: begin
                if (samp_acc) begin
                    samp_cnt_d = samp_cnt_q + SAMP_W'(1);
                    if (samp_cnt_q == SAMP_W'(SAMP_PER_BLK - 1)) begin
                        blocks_left_d = blocks_left_q - BLK_W'(1);
                        state_d = (blocks_left_q > BLK_W'(1)) ? ST_LOAD : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (outstanding_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog abort overrides everything and discards the batch.
        if (timeout) begin
            state_d       = ST_IDLE;
            blocks_left_d = '0;
            samp_cnt_d    = '0;
            outstanding_d = '0;
            wd_cnt_d      = '0;
            feed_load_d   = 1'b0;
            error_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            blocks_left_q <= '0;
            samp_cnt_q    <= '0;
            outstanding_q <= '0;
            wd_cnt_q      <= '0;
            feed_load_q   <= 1'b0;
            zero_done_q   <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            blocks_left_q <= blocks_left_d;
            samp_cnt_q    <= samp_cnt_d;
            outstanding_q <= outstanding_d;
            wd_cnt_q      <= wd_cnt_d;
            feed_load_q   <= feed_load_d;
            zero_done_q   <= zero_done_d;
            error_q       <= error_d;
        end
    end

    result_fifo #(
        .RES_W    (RES_W),
        .RES_DEPTH(RES_DEPTH)
    ) u_result_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (res_push),
        .din  (sumIn),
        .pop  (res_pop),
        .flush(timeout),
        .valid(resValid),
        .dout (resData),
        .count(fifo_count)
    );

endmodule
